// File: rtl/accel_spi_pkg.sv
// accel_spi_pkg: shared state type, command codes and
// register map constants for the accelerometer SPI responder.
package accel_spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA
  } spi_state_t;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  localparam logic [7:0] A_DEVID   = 8'h00;
  localparam logic [7:0] A_MST_ID  = 8'h01;
  localparam logic [7:0] A_PART_ID = 8'h02;
  localparam logic [7:0] A_XDATA   = 8'h08;
  localparam logic [7:0] A_YDATA   = 8'h09;
  localparam logic [7:0] A_ZDATA   = 8'h0A;
  localparam logic [7:0] A_STATUS  = 8'h0B;
  localparam logic [7:0] A_XL      = 8'h0E;
  localparam logic [7:0] A_XH      = 8'h0F;
  localparam logic [7:0] A_YL      = 8'h10;
  localparam logic [7:0] A_YH      = 8'h11;
  localparam logic [7:0] A_ZL      = 8'h12;
  localparam logic [7:0] A_ZH      = 8'h13;
  localparam logic [7:0] A_BANK_LO = 8'h1F;
  localparam logic [7:0] A_BANK_HI = 8'h2E;
  localparam logic [7:0] A_WRAP    = 8'h3F;

  localparam logic [7:0] MST_ID_VAL  = 8'h1D;
  localparam logic [7:0] PART_ID_VAL = 8'hF2;
  localparam logic [7:0] STATUS_VAL  = 8'h41;
  localparam logic [7:0] SOFT_RST_KEY = 8'h52;

  function automatic logic [7:0] hi_byte(
    input logic [11:0] s,
    input bit          sext
  );
    return sext ? {{4{s[11]}}, s[11:8]}
                : {4'h0, s[11:8]};
  endfunction

  function automatic logic [7:0] addr_inc(
    input logic [7:0] a
  );
    return (a == A_WRAP) ? 8'h00 : a + 8'h01;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with registered
// rise/fall detection on the synchronized level.
module spi_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Data flops stay unreset so a reset with the line low
  // cannot fabricate an edge.
  always_ff @(posedge clock) begin
    s1 <= din;
    s2 <= s1;
    s3 <= s2;
  end

  assign level = s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: ADXL362-style SPI slave serving
// sample registers and a small writable bank.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter bit         SIGN_EXT = 1'b1,
  parameter logic [7:0] DEVID    = 8'hAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_s1, mosi_s2;
  logic unused_sclk_lvl;

  spi_sync_edge u_sclk (
    .clock (clock),
    .reset (reset),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge u_ss (
    .clock (clock),
    .reset (reset),
    .din   (ss),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  assign unused_sclk_lvl = sclk_lvl;

  always_ff @(posedge clock) begin
    mosi_s1 <= mosi;
    mosi_s2 <= mosi_s1;
  end

  spi_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  cmd;
  logic [7:0]  addr;
  logic [11:0] snap_x, snap_y, snap_z;
  logic [7:0]  bank [16];

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [3:0] bidx;
  logic       in_bank;

  assign rx_byte = {shreg[6:0], mosi_s2};
  assign bidx    = 4'(addr - A_BANK_LO);
  assign in_bank = (addr >= A_BANK_LO) && (addr <= A_BANK_HI);

  always_comb begin
    rd_byte = 8'h00;
    if (in_bank) begin
      rd_byte = bank[bidx];
    end else begin
      case (addr)
        A_DEVID:   rd_byte = DEVID;
        A_MST_ID:  rd_byte = MST_ID_VAL;
        A_PART_ID: rd_byte = PART_ID_VAL;
        A_XDATA:   rd_byte = snap_x[11:4];
        A_YDATA:   rd_byte = snap_y[11:4];
        A_ZDATA:   rd_byte = snap_z[11:4];
        A_STATUS:  rd_byte = STATUS_VAL;
        A_XL:      rd_byte = snap_x[7:0];
        A_XH:      rd_byte = hi_byte(snap_x, SIGN_EXT);
        A_YL:      rd_byte = snap_y[7:0];
        A_YH:      rd_byte = hi_byte(snap_y, SIGN_EXT);
        A_ZL:      rd_byte = snap_z[7:0];
        A_ZH:      rd_byte = hi_byte(snap_z, SIGN_EXT);
        default:   rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      cmd      <= '0;
      addr     <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_z   <= '0;
      bank     <= '{default: 8'h00};
      miso     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (ss_rise) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (ss_fall) begin
        state   <= S_CMD;
        bit_cnt <= '0;
        miso    <= 1'b0;
        snap_x  <= x_data;
        snap_y  <= y_data;
        snap_z  <= z_data;
      end else if (state != S_IDLE && sclk_rise && !ss_lvl) begin
        shreg   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          unique case (state)
            S_CMD: begin
              cmd   <= rx_byte;
              state <= S_ADDR;
            end
            S_ADDR: begin
              addr  <= rx_byte;
              state <= S_DATA;
            end
            S_DATA: begin
              addr <= addr_inc(addr);
              if (cmd == CMD_WRITE) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= rx_byte;
                if (addr == A_BANK_LO && rx_byte == SOFT_RST_KEY)
                  bank <= '{default: 8'h00};
                else if (in_bank)
                  bank[bidx] <= rx_byte;
              end
            end
            default: ;
          endcase
        end
      end else if (state == S_DATA && sclk_fall) begin
        // bit_cnt has already wrapped at the byte boundary,
        // so ~bit_cnt selects MSB first.
        miso <= (cmd == CMD_READ) ? rd_byte[~bit_cnt] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: directed SPI master with a register
// map model; two DUTs cover SIGN_EXT=1 and SIGN_EXT=0.
module tb_accel_spi_responder;

  localparam int HALF = 63;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic [11:0] x_data = '0;
  logic [11:0] y_data = '0;
  logic [11:0] z_data = '0;
  logic        miso0, miso1;
  logic        wr_valid0, wr_valid1;
  logic [7:0]  wr_addr0, wr_addr1, wr_data0, wr_data1;

  always #5 clock = ~clock;

  accel_spi_responder dut_se (
    .clock(clock), .reset(reset), .sclk(sclk),
    .mosi(mosi), .ss(ss), .miso(miso0),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .wr_valid(wr_valid0), .wr_addr(wr_addr0),
    .wr_data(wr_data0)
  );

  accel_spi_responder #(.SIGN_EXT(1'b0)) dut_ne (
    .clock(clock), .reset(reset), .sclk(sclk),
    .mosi(mosi), .ss(ss), .miso(miso1),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .wr_valid(wr_valid1), .wr_addr(wr_addr1),
    .wr_data(wr_data1)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  txb[$];
  logic [7:0]  rx0[$];
  logic [7:0]  rx1[$];
  logic [7:0]  wd[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  mbank [16];
  logic [11:0] mx, my, mz;
  bit          rd_window = 1'b0;
  bit          done = 1'b0;
  int          chg_bit = -1;
  int          rst_bit = -1;
  int          stop_bit = -1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int sval(input logic [11:0] s);
    return s[11] ? int'(s) - 4096 : int'(s);
  endfunction

  // Register map from the sensor's point of view, in integers.
  function automatic logic [7:0] model_rd(input logic [7:0] a,
                                          input bit sext);
    logic [11:0] s;
    if (a >= 8'h1F && a <= 8'h2E) return mbank[int'(a) - 31];
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h08: return 8'(int'(mx) >> 4);
      8'h09: return 8'(int'(my) >> 4);
      8'h0A: return 8'(int'(mz) >> 4);
      8'h0B: return 8'h41;
      default: ;
    endcase
    if (a < 8'h0E || a > 8'h13) return 8'h00;
    s = (a < 8'h10) ? mx : (a < 8'h12) ? my : mz;
    if (a[0] == 1'b0) return 8'(int'(s));
    return sext ? 8'(sval(s) >>> 8) : 8'(int'(s) >> 8);
  endfunction

  task automatic spi_run();
    logic [7:0] b, r0, r1;
    int nb;
    bit stop;
    nb = 0;
    stop = 1'b0;
    rx0 = {};
    rx1 = {};
    @(posedge clock);
    #2 ss = 1'b0;
    repeat (6) @(posedge clock);
    #3;
    for (int k = 0; k < txb.size() && !stop; k++) begin
      b = txb[k];
      r0 = '0;
      r1 = '0;
      for (int i = 7; i >= 0 && !stop; i--) begin
        mosi = b[i];
        #(HALF) sclk = 1'b1;
        r0[i] = miso0;
        r1[i] = miso1;
        #(HALF) sclk = 1'b0;
        nb++;
        if (nb == 16 && txb[0] == 8'h0B) rd_window = 1'b1;
        if (nb == chg_bit) x_data = 12'h123;
        if (nb == rst_bit) begin
          @(posedge clock);
          #1 reset = 1'b1;
          @(posedge clock);
          #1 reset = 1'b0;
          rd_window = 1'b0;
          foreach (mbank[j]) mbank[j] = 8'h00;
          check("rst_miso", {miso1, miso0}, 0);
        end
        if (nb == stop_bit) stop = 1'b1;
      end
      rx0.push_back(r0);
      rx1.push_back(r1);
    end
    #(HALF);
    repeat (6) @(posedge clock);
    #2 ss = 1'b1;
    mosi = 1'b0;
    repeat (8) @(posedge clock);
    rd_window = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [7:0] a,
                         input int n);
    logic [7:0] cur;
    mx = x_data;
    my = y_data;
    mz = z_data;
    txb = {8'h0B, a};
    for (int k = 0; k < n; k++) txb.push_back(8'h00);
    spi_run();
    cur = a;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_se[%0d]", nm, i), rx0[i+2],
            model_rd(cur, 1'b1));
      check($sformatf("%s_ne[%0d]", nm, i), rx1[i+2],
            model_rd(cur, 1'b0));
      cur = (cur == 8'h3F) ? 8'h00 : cur + 8'h01;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input int stop);
    logic [7:0] cur;
    int nfull;
    txb = {8'h0A, a};
    for (int k = 0; k < wd.size(); k++) txb.push_back(wd[k]);
    nfull = (stop < 0) ? wd.size() : (stop - 16) / 8;
    cur = a;
    for (int k = 0; k < nfull; k++) begin
      exp_wr.push_back({cur, wd[k]});
      if (cur >= 8'h1F && cur <= 8'h2E) begin
        if (cur == 8'h1F && wd[k] == 8'h52)
          foreach (mbank[j]) mbank[j] = 8'h00;
        else
          mbank[int'(cur) - 31] = wd[k];
      end
      cur = (cur == 8'h3F) ? 8'h00 : cur + 8'h01;
    end
    stop_bit = stop;
    spi_run();
    stop_bit = -1;
    check("wr_left", exp_wr.size(), 0);
  endtask

  initial begin
    logic [15:0] e;
    foreach (mbank[j]) mbank[j] = 8'h00;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_miso0", miso0, 0);
    check("rst_wr_valid", wr_valid0, 0);
    check("rst_wr_addr", wr_addr0, 0);
    check("rst_wr_data", wr_data0, 0);

    fork
      begin
        do_read("id", 8'h00, 3);
        check("id_lit0", rx0[2], 8'hAD);
        check("id_lit1", rx0[3], 8'h1D);
        check("id_lit2", rx0[4], 8'hF2);

        x_data = 12'hFFE;
        y_data = 12'h07F;
        z_data = 12'h800;
        chg_bit = 32;
        do_read("burst", 8'h0E, 6);
        chg_bit = -1;
        check("burst_lit0", rx0[2], 8'hFE);
        check("burst_lit1", rx0[3], 8'hFF);
        check("burst_lit2", rx0[4], 8'h7F);
        check("burst_lit5", rx0[7], 8'hF8);
        check("noext_xh_lit", rx1[3], 8'h0F);

        do_read("top", 8'h08, 5);
        check("top_x_lit", rx0[2], 8'h12);

        wd = {8'h02};
        do_write(8'h2D, -1);
        check("hold_addr", wr_addr0, 8'h2D);
        check("hold_data", wr_data0, 8'h02);
        do_read("rb2d", 8'h2D, 1);
        check("rb2d_lit", rx0[2], 8'h02);

        wd = {8'h13};
        do_write(8'h2C, -1);
        do_read("rb2c", 8'h2C, 1);
        wd = {8'h52};
        do_write(8'h1F, -1);
        do_read("soft", 8'h1F, 14);
        check("soft_1f_lit", rx0[2], 8'h00);
        check("soft_2c_lit", rx0[15], 8'h00);

        wd = {8'hA5};
        do_write(8'h20, -1);
        wd = {8'h5A};
        do_write(8'h20, 20);
        do_read("abort", 8'h20, 1);
        check("abort_lit", rx0[2], 8'hA5);

        wd = {8'h11, 8'h22};
        do_write(8'h2E, -1);
        do_read("edge", 8'h2E, 2);
        do_read("wrap", 8'h3F, 2);
        check("wrap_lit", rx0[3], 8'hAD);

        txb = {8'h0B, 8'h20, 8'h00, 8'h00, 8'h00};
        rst_bit = 20;
        spi_run();
        rst_bit = -1;
        do_read("after_rst", 8'h00, 3);
        do_read("bank_rst", 8'h20, 1);

        txb = {8'h0D, 8'h00, 8'h00, 8'h00};
        spi_run();
        check("unk_rx", rx0[2], 8'h00);
        wd = {8'h77};
        txb = {8'h0C, 8'h20, 8'h77};
        spi_run();
        do_read("unk_bank", 8'h20, 1);

        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clock);
          if (!rd_window)
            check("miso_idle", {miso1, miso0}, 0);
          if (wr_valid0 || wr_valid1) begin
            if (exp_wr.size() == 0) begin
              check("wr_spurious", {wr_valid1, wr_valid0}, 0);
            end else begin
              e = exp_wr.pop_front();
              check("wr_se", {wr_valid0, wr_addr0, wr_data0},
                    {1'b1, e});
              check("wr_ne", {wr_valid1, wr_addr1, wr_data1},
                    {1'b1, e});
            end
          end
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
# accel_spi_responder

SPI slave model of the ADXL362-style accelerometer that the on-board accelerometer controller talks to: it answers register read/write transactions on SCLK/MOSI/MISO/SS, serving X/Y/Z sample registers supplied on parallel inputs. It sits on the far end of the accelerometer SPI link. Its uses are:
- Simulation and loopback benches, where it replaces the physical sensor.
- Board builds where a scripted "virtual tilt" drives the game instead of the real sensor.

## Interface
- `SIGN_EXT`, default 1: when 1, each `*_H` register holds the 4 sign bits of the 12-bit sample followed by sample bits [11:8] (ADXL362 format). When 0, the upper nibble is 0.
- `DEVID`, default 8'hAD: value returned at address 0x00.

Ports:
- `clock`  in  1  system clock; the only clock. `sclk` is sampled as data.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0), asynchronous to `clock`.
- `mosi`  in  1  master-out data, MSB first.
- `ss`  in  1  active-low slave select, asynchronous.
- `miso`  out  1  slave-out data, MSB first. Driven 0 whenever not in DATA read.
- `x_data`, `y_data`, `z_data`  in  12 each  two's-complement samples.
- `wr_valid`  out  1  one-`clock` pulse per completed write byte.
- `wr_addr`  out  8  register address of that write.
- `wr_data`  out  8  byte written.

## Operation
- **Input synchronization:** `sclk`, `mosi` and `ss` each pass through a 2-flop synchronizer. Rising and falling `sclk` edges are detected from the synchronized copies, one `clock` after synchronization.
- **Sample snapshot:** on synchronized `ss` falling, `x_data`/`y_data`/`z_data` are latched. All reads in that transaction use the latched values, so multi-byte reads are coherent.
- **State machine:** IDLE → CMD → ADDR → DATA.
  - IDLE → CMD on `ss` falling.
  - CMD → ADDR after 8 rising edges (command byte).
  - ADDR → DATA after 8 more rising edges (address byte).
  - DATA repeats bytes until `ss` rises.
  - `ss` rising in any state → IDLE. A partial byte is discarded and no `wr_valid` is generated.
- **Commands:**
  - 0x0B is a read.
  - 0x0A is a write.
  - Any other value is ignored: stay in CMD/ADDR/DATA counting bits, `miso`=0, no writes.
- **Bit handling:** MOSI is shifted in on `sclk` rising edges. In DATA read, MISO shifts out on `sclk` falling edges. The MSB of each read byte is placed on `miso` at the falling edge that ends the previous byte, i.e. the 16th falling edge for the first data byte.
- **Address auto-increment:** the address increments after every data byte. It wraps 0x3F → 0x00.
- **Register map (reads):**
  - 0x00 = `DEVID`
  - 0x01 = 0x1D
  - 0x02 = 0xF2
  - 0x08/0x09/0x0A = X[11:4]/Y[11:4]/Z[11:4]
  - 0x0B = 0x41 (STATUS: DATA_READY and AWAKE set)
  - 0x0E/0x0F = X_L/X_H
  - 0x10/0x11 = Y_L/Y_H
  - 0x12/0x13 = Z_L/Z_H
  - 0x1F–0x2E = writable bank
  - all other addresses = 0x00
- **Writable bank:** 16 bytes.
  - Writes inside 0x1F–0x2E update the bank; writes elsewhere are dropped.
  - `wr_valid` pulses for every completed write byte regardless of address.
  - Writing 0x52 to 0x1F (SOFT_RESET) clears the whole bank to 0x00 in the same cycle as the `wr_valid` pulse. The bank then reads 0x00, not 0x52.
- **Reset values:**
  - `miso`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0
  - state IDLE, bit counter 0, writable bank all 0x00, snapshot 0

## Timing
- `sclk` frequency must be ≤ `clock`/8, and `ss` setup/hold must be ≥ 4 `clock` cycles around the first and last `sclk` edges.
- `miso` changes 4 `clock` cycles after the pin-level `sclk` falling edge: 2 synchronizer + 1 edge detect + 1 output register.
- `wr_valid` asserts 4 `clock` cycles after the 8th rising edge of a write data byte and stays high exactly 1 cycle. `wr_addr`/`wr_data` hold their values until the next pulse.
- Synchronous `reset` mid-transaction forces IDLE next cycle. The rest of that transaction is ignored until `ss` has been seen high, then low again.
- If a rising and falling edge would coincide, the falling edge cannot occur in the same cycle by construction of the ≤ `clock`/8 rule, so no priority is defined.

## Structure
- Package `accel_spi_pkg` holds:
  - state enum (IDLE/CMD/ADDR/DATA)
  - command constants CMD_READ=0x0B and CMD_WRITE=0x0A
  - register address constants
  - fixed ID values
  - SOFT_RESET key 0x52
- Sub-module `spi_sync_edge` is a 2-flop synchronizer plus edge detector for `sclk` and `ss`, with outputs rise, fall and level. It is instantiated once per signal.
- The read mux and writable bank are inline.

## Test plan
- **ID read:** master sends 0x0B,0x00 then clocks 3 bytes → MISO returns 0xAD, 0x1D, 0xF2.
- **Burst sample read:** x=12'hFFE, y=12'h07F, z=12'h800; read from 0x0E for 6 bytes → 0xFE,0xFF,0x7F,0x00,0x00,0xF8. Changing x mid-burst does not alter bytes already latched.
- **Write:** 0x0A,0x2D,0x02 → single `wr_valid` with `wr_addr`=0x2D, `wr_data`=0x02; a following read of 0x2D returns 0x02.
- **Soft reset:**
  - Write 0x2C=0x13, then 0x1F=0x52 → reads of 0x2C and 0x1F both return 0x00.
  - With `SIGN_EXT`=0, read of 0x0F for x=12'hFFE returns 0x0F.
- **Abort and reset:**
  - `ss` raised after 4 bits of a write data byte → no `wr_valid`, bank unchanged.
  - `reset` pulsed mid-read → `miso`=0 within 1 cycle; the next full transaction reads correctly.
  - Unknown command 0x0D → `miso` stays 0 for the whole transaction.
